// File: rtl/mem_burst_master.sv
// DDR2 local-interface burst initiator: splits one linear transfer command
// into BURST_MAX-aligned bursts, moving data write-FIFO -> DDR2 or
// DDR2 -> read-FIFO. Single clock domain (phy_clk).
module mem_burst_master #(
  parameter int unsigned BURST_MAX = 4,
  parameter int unsigned FIFO_AW   = 10
) (
  input  logic               phy_clk,
  input  logic               reset_phy_clk_n,
  input  logic               local_init_done,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_write,
  input  logic [23:0]        cmd_addr,
  input  logic [15:0]        cmd_beats,
  output logic               busy,
  output logic               done,
  output logic               err_unexp,
  input  logic [63:0]        wf_data,
  input  logic [FIFO_AW-1:0] wf_count,
  output logic               wf_rd,
  output logic [63:0]        rf_data,
  output logic               rf_wr,
  input  logic [FIFO_AW-1:0] rf_free,
  input  logic               local_ready,
  output logic               local_burstbegin,
  output logic [23:0]        local_address,
  output logic [3:0]         local_size,
  output logic [7:0]         local_be,
  output logic               local_write_req,
  output logic [63:0]        local_wdata,
  output logic               local_read_req,
  input  logic               local_rdata_valid,
  input  logic [63:0]        local_rdata
);

  localparam int unsigned PW = FIFO_AW + 1;  // pending-beat counter width
  localparam int unsigned CW = FIFO_AW + 5;  // width for FIFO level compares
  localparam logic [23:0] ALIGN_MASK = 24'(BURST_MAX - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_DRAIN
  } state_e;

  state_e          state_q, state_d;
  logic [23:0]     addr_q, addr_d;
  logic [15:0]     rem_q, rem_d;
  logic [3:0]      wcnt_q, wcnt_d;
  logic [PW-1:0]   pend_q, pend_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [63:0]     rf_data_q;
  logic            rf_wr_q;

  logic [4:0]      room;
  logic [3:0]      size_c;
  logic            cmd_acc, wr_go, rd_go, wr_acc, rd_acc;
  logic            last_beat, last_burst, ret, unexp;

  // Burst size: limited by remaining beats and the next BURST_MAX boundary
  always_comb begin
    room   = 5'(BURST_MAX) - 5'(addr_q & ALIGN_MASK);
    size_c = (rem_q < 16'(room)) ? rem_q[3:0] : room[3:0];
  end

  // Request/handshake qualifiers shared by the FSM and the datapath.
  // A write burst is launched combinationally once the FIFO holds a whole
  // burst; after its first beat is taken it continues regardless of level.
  always_comb begin
    cmd_acc    = cmd_valid & cmd_ready;
    wr_go      = (state_q == S_WR) &
                 ((wcnt_q != 4'd0) || (CW'(wf_count) >= CW'(size_c)));
    rd_go      = (state_q == S_RD) &
                 (CW'(rf_free) >= (CW'(pend_q) + CW'(size_c)));
    wr_acc     = wr_go & local_ready;
    rd_acc     = rd_go & local_ready;
    last_beat  = (wcnt_q == (size_c - 4'd1));
    last_burst = (rem_q == 16'(size_c));
    ret        = local_rdata_valid & (pend_q != '0);
    unexp      = local_rdata_valid & (pend_q == '0);
  end

  // FSM state register
  always_ff @(posedge phy_clk or negedge reset_phy_clk_n) begin
    if (!reset_phy_clk_n) state_q <= S_IDLE;
    else                  state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (cmd_acc && (cmd_beats != 16'd0)) state_d = cmd_write ? S_WR : S_RD;
      S_WR:    if (wr_acc && last_beat && last_burst) state_d = S_IDLE;
      S_RD:    if (rd_acc && last_burst) state_d = S_DRAIN;
      S_DRAIN: if (ret && (pend_q == PW'(1))) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: memory request signals are zero whenever no request is up
  always_comb begin
    cmd_ready        = (state_q == S_IDLE) & local_init_done;
    busy             = (state_q != S_IDLE);
    local_write_req  = wr_go;
    local_read_req   = rd_go;
    local_burstbegin = (wr_go & (wcnt_q == 4'd0)) | rd_go;
    local_address    = (wr_go | rd_go) ? addr_q : '0;
    local_size       = (wr_go | rd_go) ? size_c : '0;
    wf_rd            = wr_acc;
  end

  // Datapath next-state: address/remaining/beat/pending bookkeeping
  always_comb begin
    addr_d = addr_q;
    rem_d  = rem_q;
    wcnt_d = wcnt_q;
    done_d = 1'b0;
    err_d  = err_q | unexp;
    if (cmd_acc) begin
      addr_d = cmd_addr;
      rem_d  = cmd_beats;
      wcnt_d = '0;
      if (cmd_beats == 16'd0) done_d = 1'b1;
    end
    if (wr_acc) begin
      if (last_beat) begin
        wcnt_d = '0;
        addr_d = addr_q + 24'(size_c);
        rem_d  = rem_q - 16'(size_c);
        if (last_burst) done_d = 1'b1;
      end else begin
        wcnt_d = wcnt_q + 4'd1;
      end
    end
    if (rd_acc) begin
      addr_d = addr_q + 24'(size_c);
      rem_d  = rem_q - 16'(size_c);
    end
    // Accept and return in the same cycle net to +size-1
    pend_d = pend_q + (rd_acc ? PW'(size_c) : '0) - (ret ? PW'(1) : '0);
    if ((state_q == S_DRAIN) && ret && (pend_q == PW'(1))) done_d = 1'b1;
  end

  // Datapath registers
  always_ff @(posedge phy_clk or negedge reset_phy_clk_n) begin
    if (!reset_phy_clk_n) begin
      addr_q <= '0;
      rem_q  <= '0;
      wcnt_q <= '0;
      pend_q <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      addr_q <= addr_d;
      rem_q  <= rem_d;
      wcnt_q <= wcnt_d;
      pend_q <= pend_d;
      done_q <= done_d;
      err_q  <= err_d;
    end
  end

  // Read return path: register returned beats into the read FIFO
  always_ff @(posedge phy_clk or negedge reset_phy_clk_n) begin
    if (!reset_phy_clk_n) begin
      rf_data_q <= '0;
      rf_wr_q   <= 1'b0;
    end else begin
      rf_wr_q <= ret;
      if (ret) rf_data_q <= local_rdata;
    end
  end

  assign done        = done_q;
  assign err_unexp   = err_q;
  assign rf_data     = rf_data_q;
  assign rf_wr       = rf_wr_q;
  assign local_be    = 8'hFF;
  assign local_wdata = wf_data;

endmodule

// File: tb/tb_mem_burst_master.sv
// Scoreboard bench for mem_burst_master: stimulus pushes expected beats,
// requests, read-FIFO data and done events; monitors pop and compare.
module tb_mem_burst_master;

  localparam int unsigned FAW = 10;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            init_done;
  logic            cmd_valid, cmd_ready, cmd_write;
  logic [23:0]     cmd_addr;
  logic [15:0]     cmd_beats;
  logic            busy, done, err_unexp;
  logic [63:0]     wf_data;
  logic [FAW-1:0]  wf_count;
  logic            wf_rd;
  logic [63:0]     rf_data;
  logic            rf_wr;
  logic [FAW-1:0]  rf_free;
  logic            local_ready;
  logic            bb;
  logic [23:0]     laddr;
  logic [3:0]      lsize;
  logic [7:0]      lbe;
  logic            wreq, rreq;
  logic [63:0]     wdata;
  logic            rvalid;
  logic [63:0]     rdata;

  mem_burst_master #(.BURST_MAX(4), .FIFO_AW(FAW)) dut (
    .phy_clk(clk), .reset_phy_clk_n(rst_n), .local_init_done(init_done),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_beats(cmd_beats), .busy(busy), .done(done),
    .err_unexp(err_unexp), .wf_data(wf_data), .wf_count(wf_count), .wf_rd(wf_rd),
    .rf_data(rf_data), .rf_wr(rf_wr), .rf_free(rf_free), .local_ready(local_ready),
    .local_burstbegin(bb), .local_address(laddr), .local_size(lsize), .local_be(lbe),
    .local_write_req(wreq), .local_wdata(wdata), .local_read_req(rreq),
    .local_rdata_valid(rvalid), .local_rdata(rdata)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] wf_pat(input int i);
    return {32'hCAFE_0000 + 32'(i), ~32'(i)};
  endfunction

  function automatic logic [63:0] mem_data(input logic [23:0] a);
    return {16'hD0D0, a, ~a};
  endfunction

  // Write FIFO model (first-word fall-through)
  int wf_head = 0;
  int wf_tail = 0;
  always @(posedge clk) if (wf_rd) wf_head <= wf_head + 1;
  assign wf_data  = wf_pat(wf_head);
  assign wf_count = FAW'(wf_tail - wf_head);

  // Memory read responder, fixed latency
  typedef struct { int due; logic [63:0] d; } ret_t;
  ret_t retq[$];
  int   cyc = 0;
  logic stray = 1'b0;
  always @(negedge clk)
    if (rst_n && rreq && local_ready)
      for (int j = 0; j < int'(lsize); j++)
        retq.push_back('{cyc + 5 + j, mem_data(laddr + 24'(j))});
  always @(posedge clk) begin
    cyc++;
    #2;
    if (retq.size() > 0 && retq[0].due <= cyc) begin
      rvalid = 1'b1;
      rdata  = retq[0].d;
      void'(retq.pop_front());
    end else begin
      rvalid = stray;
      rdata  = '0;
    end
  end

  // Scoreboard queues
  typedef struct packed { logic bb; logic [23:0] a; logic [3:0] s; logic [63:0] d; } wexp_t;
  wexp_t        wq[$];
  logic [27:0]  rq[$];
  logic [63:0]  rfq[$];
  int           dq[$];   // 0: zero-beat, 1: write, 2: read
  int           nxt_wf = 0;

  int wacc_cnt = 0, wfrd_cnt = 0, rreq_cnt = 0, done_cnt = 0;
  logic prev_wacc = 1'b0, prev_cacc = 1'b0;

  task automatic exp_wburst(input logic [23:0] a, input int unsigned s);
    for (int unsigned k = 0; k < s; k++) begin
      wq.push_back('{bb: (k == 0), a: a, s: 4'(s), d: wf_pat(nxt_wf)});
      nxt_wf++;
    end
  endtask

  task automatic exp_rburst(input logic [23:0] a, input int unsigned s);
    rq.push_back({a, 4'(s)});
    for (int unsigned k = 0; k < s; k++) rfq.push_back(mem_data(a + 24'(k)));
  endtask

  // Monitor: compares every presented beat/request/push/done against queues
  always @(negedge clk) begin
    logic wacc;
    int   mode;
    if (!rst_n) begin
      prev_wacc = 1'b0;
      prev_cacc = 1'b0;
    end else begin
      wacc = wreq & local_ready;
      if (wreq) begin
        if (wq.size() == 0) chk("wr_unexpected", 1, 0);
        else if (local_ready) begin
          chk("wr_beat", {bb, laddr, lsize, wdata}, wq[0]);
          void'(wq.pop_front());
        end else chk("wr_hold", {bb, laddr, lsize, wdata}, wq[0]);
      end
      if (wreq || wf_rd) chk("wf_rd", wf_rd, wacc);
      if (wacc) wacc_cnt++;
      if (wf_rd) wfrd_cnt++;
      if (rreq) begin
        if (rq.size() == 0) chk("rd_unexpected", 1, 0);
        else begin
          chk("rd_req", {bb, laddr, lsize}, {1'b1, rq[0]});
          if (local_ready) begin
            void'(rq.pop_front());
            rreq_cnt++;
          end
        end
      end
      if (rf_wr) begin
        if (rfq.size() == 0) chk("rf_unexpected", 1, 0);
        else begin
          chk("rf_data", rf_data, rfq[0]);
          void'(rfq.pop_front());
        end
      end
      if (done) begin
        done_cnt++;
        if (dq.size() == 0) chk("done_unexpected", 1, 0);
        else begin
          mode = dq.pop_front();
          case (mode)
            0:       chk("done_zero", prev_cacc, 1);
            1:       chk("done_wr", prev_wacc, 1);
            default: chk("done_rd", {rf_wr, rfq.size() == 0}, 2'b11);
          endcase
        end
      end
      prev_wacc = wacc;
      prev_cacc = cmd_valid & cmd_ready;
    end
  end

  task automatic send_cmd(input logic w, input logic [23:0] a, input logic [15:0] n);
    bit ok = 0;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_beats = n;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1; break; end
    end
    chk("cmd_accept", ok, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int tgt = done_cnt + 1;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (done_cnt >= tgt) break;
    end
    chk(nm, done_cnt >= tgt, 1);
  endtask

  task automatic chk_empty(input string nm);
    chk(nm, {wq.size() == 0, rq.size() == 0, rfq.size() == 0, dq.size() == 0}, 4'hF);
  endtask

  function automatic logic [108:0] out_vec();
    return {cmd_ready, busy, done, err_unexp, wf_rd, rf_wr, rf_data,
            bb, laddr, lsize, lbe, wreq, rreq};
  endfunction

  localparam logic [108:0] RST_VEC = {6'b0, 64'h0, 1'b0, 24'h0, 4'h0, 8'hFF, 2'b00};

  initial begin
    int base;
    rst_n = 1'b0; init_done = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0;
    cmd_addr = '0; cmd_beats = '0; local_ready = 1'b1; rf_free = FAW'(100);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", out_vec(), RST_VEC);
    @(posedge clk); #1;
    rst_n = 1'b1; init_done = 1'b1;

    // 1: write 8 @0x10 -> 4@10, 4@14
    wf_tail = wf_head + 8; nxt_wf = wf_head; base = wfrd_cnt;
    exp_wburst(24'h000010, 4); exp_wburst(24'h000014, 4); dq.push_back(1);
    send_cmd(1'b1, 24'h000010, 16'd8);
    wait_done("t1_done");
    chk("t1_wf_rd_count", wfrd_cnt - base, 8);
    chk_empty("t1_drained");

    // 2: write 6 @0x03 -> 1@03, 4@04, 1@08
    wf_tail = wf_head + 6; nxt_wf = wf_head;
    exp_wburst(24'h000003, 1); exp_wburst(24'h000004, 4); exp_wburst(24'h000008, 1);
    dq.push_back(1);
    send_cmd(1'b1, 24'h000003, 16'd6);
    wait_done("t2_done");
    chk_empty("t2_drained");

    // 3: ready low for 3 cycles mid-burst
    wf_tail = wf_head + 8; nxt_wf = wf_head; base = wacc_cnt;
    exp_wburst(24'h000020, 4); exp_wburst(24'h000024, 4); dq.push_back(1);
    send_cmd(1'b1, 24'h000020, 16'd8);
    for (int i = 0; i < 50; i++) begin
      if (wacc_cnt >= base + 2) break;
      @(posedge clk); #1;
    end
    local_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 local_ready = 1'b1;
    wait_done("t3_done");
    chk("t3_beats", wacc_cnt - base, 8);
    chk_empty("t3_drained");

    // 4: read 4 @0xFFFFFE -> 2@FFFFFE, 2@000000 (address wrap)
    exp_rburst(24'hFFFFFE, 2); exp_rburst(24'h000000, 2); dq.push_back(2);
    send_cmd(1'b0, 24'hFFFFFE, 16'd4);
    wait_done("t4_done");
    chk_empty("t4_drained");
    chk("t4_no_err", err_unexp, 0);

    // 5: read 8 @0x102 with rf_free=2 -> one 2-beat burst, then stall
    rf_free = FAW'(2); base = rreq_cnt;
    exp_rburst(24'h000102, 2); exp_rburst(24'h000104, 4); exp_rburst(24'h000108, 2);
    dq.push_back(2);
    send_cmd(1'b0, 24'h000102, 16'd8);
    repeat (25) @(posedge clk);
    #1 chk("t5_stalled", rreq_cnt - base, 1);
    chk("t5_busy", busy, 1);
    rf_free = FAW'(10);
    wait_done("t5_done");
    chk_empty("t5_drained");

    // zero-beat command: done pulse, no memory traffic
    dq.push_back(0);
    send_cmd(1'b1, 24'h000055, 16'd0);
    wait_done("t5_zero_done");
    repeat (3) @(posedge clk);
    #1 chk("t5_zero_idle", {busy, wreq, rreq}, 3'b000);
    chk_empty("t5_zero_drained");

    // 6: reset in the middle of a stalled write burst
    local_ready = 1'b0;
    wf_tail = wf_head + 8; nxt_wf = wf_head;
    exp_wburst(24'h000040, 4);
    send_cmd(1'b1, 24'h000040, 16'd8);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0; init_done = 1'b0;
    @(negedge clk);
    chk("t6_reset_outputs", out_vec(), RST_VEC);
    wq.delete();
    wf_tail = wf_head;
    @(posedge clk); #1;
    rst_n = 1'b1; local_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("t6_no_ready_uncal", {cmd_ready, err_unexp}, 2'b00);
    stray = 1'b1;
    @(posedge clk); #1 stray = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("t6_err_set", {err_unexp, busy}, 2'b10);
    repeat (3) @(posedge clk);
    #1 chk("t6_err_sticky", err_unexp, 1);
    chk_empty("t6_drained");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
